// File: rtl/decode_pkg.sv
`default_nettype none
// ==========================================================================
// decode_pkg : shared decode types, default widths and index-match helper
// Rev 1.0
// ==========================================================================
package decode_pkg;

  localparam int DATA_W_DEFAULT = 32;
  localparam int ADDR_W_DEFAULT = 5;
  localparam int ZERO_REG       = 0;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
  } ctrl_t;

  // Register-index equality, with the zero register excluded when it is hardwired
  function automatic logic idx_match(input logic [31:0] a,
                                     input logic [31:0] b,
                                     input logic        zero_hw);
    return (a == b) && !(zero_hw && (a == 32'(ZERO_REG)));
  endfunction

endpackage
`default_nettype wire

// File: rtl/id_ex_hazard.sv
`default_nettype none
// ==========================================================================
// id_ex_hazard : load-use detection against the held entry and a one-cycle
//                shadow of the last load that left the stage
// Rev 1.0
// ==========================================================================
module id_ex_hazard
  import decode_pkg::*;
#(
  parameter int ADDR_W             = ADDR_W_DEFAULT,
  parameter bit ZERO_REG_HARDWIRED = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic              held_valid,
  input  logic              held_ready,
  input  logic              held_mem_read,
  input  logic [ADDR_W-1:0] held_rd,
  input  logic              flush,
  output logic              load_use
);

  logic              r_ld_vld;
  logic [ADDR_W-1:0] r_ld_rd;
  logic              w_held_load;
  logic              w_load_leaves;
  logic              w_hit_held;
  logic              w_hit_shadow;

  assign w_held_load   = held_valid & held_mem_read;
  assign w_load_leaves = w_held_load & held_ready & ~flush;

  assign w_hit_held   = idx_match(32'(rs1), 32'(held_rd), ZERO_REG_HARDWIRED)
                      | idx_match(32'(rs2), 32'(held_rd), ZERO_REG_HARDWIRED);
  assign w_hit_shadow = idx_match(32'(rs1), 32'(r_ld_rd), ZERO_REG_HARDWIRED)
                      | idx_match(32'(rs2), 32'(r_ld_rd), ZERO_REG_HARDWIRED);

  assign load_use = in_valid & ((w_held_load & w_hit_held) | (r_ld_vld & w_hit_shadow));

  // Shadow lives for exactly the cycle after a load is consumed by EX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ld_vld <= 1'b0;
      r_ld_rd  <= '0;
    end else begin
      r_ld_vld <= w_load_leaves;
      if (w_load_leaves) begin
        r_ld_rd <= held_rd;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ==========================================================================
// id_ex_stage : one-entry decode-to-execute buffer with load-use bubble,
//               flush, and optional writeback bypass (ID_EX_WB_BYPASS_EN)
// Rev 1.0
// ==========================================================================
module id_ex_stage
  import decode_pkg::*;
#(
  parameter int DATA_W             = DATA_W_DEFAULT,
  parameter int ADDR_W             = ADDR_W_DEFAULT,
  parameter bit ZERO_REG_HARDWIRED = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] Rs1,
  input  logic [ADDR_W-1:0] Rs2,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] Rout1,
  input  logic [DATA_W-1:0] Rout2,
  input  logic [DATA_W-1:0] imm,
  input  ctrl_t             ctrl,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_rs1,
  output logic [ADDR_W-1:0] out_rs2,
  output logic [ADDR_W-1:0] out_rd,
  output logic [DATA_W-1:0] out_op1,
  output logic [DATA_W-1:0] out_op2,
  output logic [DATA_W-1:0] out_imm,
  output ctrl_t             out_ctrl
);

  logic              r_valid;
  logic [ADDR_W-1:0] r_rs1;
  logic [ADDR_W-1:0] r_rs2;
  logic [ADDR_W-1:0] r_rd;
  logic [DATA_W-1:0] r_op1;
  logic [DATA_W-1:0] r_op2;
  logic [DATA_W-1:0] r_imm;
  ctrl_t             r_ctrl;

  logic              w_load_use;
  logic              w_accept;
  logic [DATA_W-1:0] w_cap_op1;
  logic [DATA_W-1:0] w_cap_op2;
  logic [DATA_W-1:0] w_hold_op1;
  logic [DATA_W-1:0] w_hold_op2;

  id_ex_hazard #(
    .ADDR_W             (ADDR_W),
    .ZERO_REG_HARDWIRED (ZERO_REG_HARDWIRED)
  ) u_hazard (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .rs1           (Rs1),
    .rs2           (Rs2),
    .held_valid    (r_valid),
    .held_ready    (out_ready),
    .held_mem_read (r_ctrl.mem_read),
    .held_rd       (r_rd),
    .flush         (flush),
    .load_use      (w_load_use)
  );

  assign in_ready = (~r_valid | out_ready) & ~w_load_use & ~flush;
  assign w_accept = in_valid & in_ready;

`ifdef ID_EX_WB_BYPASS_EN
  // Writeback landing this cycle is newer than what the register file returned
  always_comb begin
    w_cap_op1  = Rout1;
    w_cap_op2  = Rout2;
    w_hold_op1 = r_op1;
    w_hold_op2 = r_op2;
    if (wb_en && idx_match(32'(wb_rd), 32'(Rs1), ZERO_REG_HARDWIRED))   w_cap_op1  = wb_data;
    if (wb_en && idx_match(32'(wb_rd), 32'(Rs2), ZERO_REG_HARDWIRED))   w_cap_op2  = wb_data;
    if (wb_en && idx_match(32'(wb_rd), 32'(r_rs1), ZERO_REG_HARDWIRED)) w_hold_op1 = wb_data;
    if (wb_en && idx_match(32'(wb_rd), 32'(r_rs2), ZERO_REG_HARDWIRED)) w_hold_op2 = wb_data;
  end
`else
  logic w_unused_wb;
  assign w_unused_wb = ^{wb_en, wb_rd, wb_data};

  always_comb begin
    w_cap_op1  = Rout1;
    w_cap_op2  = Rout2;
    w_hold_op1 = r_op1;
    w_hold_op2 = r_op2;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_rd    <= '0;
      r_op1   <= '0;
      r_op2   <= '0;
      r_imm   <= '0;
      r_ctrl  <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_rs1   <= Rs1;
      r_rs2   <= Rs2;
      r_rd    <= rd;
      r_op1   <= w_cap_op1;
      r_op2   <= w_cap_op2;
      r_imm   <= imm;
      r_ctrl  <= ctrl;
    end else if (r_valid && out_ready) begin
      r_valid <= 1'b0;
    end else if (r_valid) begin
      r_op1 <= w_hold_op1;
      r_op2 <= w_hold_op2;
    end
  end

  assign out_valid = r_valid;
  assign out_rs1   = r_rs1;
  assign out_rs2   = r_rs2;
  assign out_rd    = r_rd;
  assign out_op1   = r_op1;
  assign out_op2   = r_op2;
  assign out_imm   = r_imm;
  assign out_ctrl  = r_ctrl;

endmodule
`default_nettype wire
